// File: rtl/wt_cache_maint_ctrl.sv
// Cache-maintenance sequencer: drains the write buffer, flushes D$ and/or I$ in a fixed order
// and signals completion with a one-cycle done pulse; a watchdog flags stalled operations.
module wt_cache_maint_ctrl #(
   parameter int unsigned TimeoutCycles = 4096
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_valid_i,
   input  logic [1:0] req_op_i,
   output logic       req_ready_o,
   output logic       done_o,
   output logic       timeout_o,
   output logic       busy_o,
   input  logic       wbuffer_empty_i,
   output logic       dcache_flush_o,
   input  logic       dcache_flush_ack_i,
   output logic       icache_flush_o
);

   localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntMax     = '1;
   localparam logic [CntW-1:0] TimeoutVal = CntW'(TimeoutCycles);
   localparam logic [1:0]      OpFenceI   = 2'd1;
   localparam logic [1:0]      OpFlushAll = 2'd2;

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StDflush,
      StIflush,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_q, timeout_d;
   logic            counting;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         op_q      <= 2'd0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign counting = (state_q == StDrain) || (state_q == StDflush);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;

      // Watchdog only flags; the counter saturates so the equality fires once per operation.
      if (counting) begin
         if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
         end
         if ((TimeoutCycles != 0) && (cnt_d == TimeoutVal)) begin
            timeout_d = 1'b1;
         end
      end

      case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               op_d      = req_op_i;
               cnt_d     = '0;
               timeout_d = 1'b0;
               state_d   = StDrain;
            end
         end
         StDrain: begin
            if (wbuffer_empty_i) begin
               case (op_q)
                  OpFenceI:   state_d = StIflush;
                  OpFlushAll: state_d = StDflush;
                  default:    state_d = StDone;
               endcase
            end
         end
         StDflush: begin
            if (dcache_flush_ack_i) begin
               state_d = StIflush;
            end
         end
         StIflush: state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   assign req_ready_o    = (state_q == StIdle);
   assign busy_o         = (state_q != StIdle);
   assign done_o         = (state_q == StDone);
   assign dcache_flush_o = (state_q == StDflush);
   assign icache_flush_o = (state_q == StIflush);
   assign timeout_o      = timeout_q;

endmodule

// File: doc/wt_cache_maint_ctrl.md
# wt_cache_maint_ctrl

Cache-maintenance sequencer for the write-through cache subsystem. It accepts one maintenance request at a time (FENCE, FENCE.I, FLUSH_ALL) from the issue or CSR side. It then drives the cache subsystem's write-buffer-drain wait, D$ flush handshake and I$ flush pulse in a fixed order, and reports completion with a single-cycle done pulse. A watchdog flags maintenance operations that stall.

## Interface
Parameters:
- TimeoutCycles, default 4096: watchdog threshold in cycles spent in DRAIN+DFLUSH. 0 disables the watchdog. Counter width is $clog2(TimeoutCycles+1), minimum 1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- req_valid_i  in  1  maintenance request valid; requester holds it until accepted
- req_op_i  in  2  0=FENCE, 1=FENCE_I, 2=FLUSH_ALL, 3=treated as FENCE
- req_ready_o  out  1  high only in IDLE
- done_o  out  1  one-cycle completion pulse
- timeout_o  out  1  sticky watchdog flag, cleared on the next accepted request
- busy_o  out  1  state != IDLE
- wbuffer_empty_i  in  1  write buffer empty, from the D$
- dcache_flush_o  out  1  to D$ flush_i; held until acknowledged
- dcache_flush_ack_i  in  1  D$ flush acknowledge, single-cycle
- icache_flush_o  out  1  to I$ flush_i; single-cycle pulse

## Operation
- Implemented as a Moore FSM: IDLE, DRAIN, DFLUSH, IFLUSH, DONE. All outputs decode from registered state or flags, never from inputs.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch req_op_i into op_q, clear timeout_o and the watchdog counter, then go to DRAIN.
- DRAIN: wait for wbuffer_empty_i=1 sampled at a clock edge. Then:
  - op_q FENCE (or 3) -> DONE
  - FENCE_I -> IFLUSH
  - FLUSH_ALL -> DFLUSH
- DFLUSH:
  - dcache_flush_o=1.
  - On the edge where dcache_flush_ack_i=1, go to IFLUSH. dcache_flush_o drops in the following cycle.
- IFLUSH: icache_flush_o=1 for exactly one cycle, then DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Watchdog:
  - Counter increments every cycle in DRAIN or DFLUSH and saturates.
  - When it equals TimeoutCycles (TimeoutCycles>0), set timeout_o.
  - The watchdog only flags. It never forces a state change, and the sequence completes normally once the condition clears.
- dcache_flush_ack_i outside DFLUSH is ignored.
- req_valid_i outside IDLE is ignored; the request is not lost because the requester holds it.
- op_q is stable from acceptance to DONE; req_op_i changes after acceptance have no effect.

## Timing
- Reset (asynchronous, immediate): state=IDLE, op_q=0, counter=0, timeout_o=0. Resulting outputs: req_ready_o=1, busy_o=0, done_o=0, dcache_flush_o=0, icache_flush_o=0.
- Reset asserted mid-operation (including DFLUSH) returns to IDLE immediately. dcache_flush_o drops with no ack required, because the D$ is reset by the same rst_ni.
- Latencies, with acceptance at edge T and an already-empty write buffer:
  - FENCE: DRAIN in cycle T+1, done_o in cycle T+2, req_ready_o again in T+3.
  - FENCE_I: DRAIN T+1, icache_flush_o T+2, done_o T+3.
  - FLUSH_ALL with ack in the first DFLUSH cycle: DRAIN T+1, dcache_flush_o T+2, icache_flush_o T+3, done_o T+4.
- Each cycle that wbuffer_empty_i stays low in DRAIN adds one cycle. Each DFLUSH cycle without ack adds one cycle.
- Back-to-back requests: the minimum spacing between acceptances is 3 cycles (FENCE). The cycle after DONE is IDLE, and a held req_valid_i is accepted there.
- Simultaneous events:
  - timeout reached in the same cycle the DRAIN exit condition holds: timeout_o still sets, and the exit proceeds.
  - ack and timeout in the same cycle: both take effect.

## Test plan
- Reset, then FENCE with wbuffer_empty_i=1 at acceptance T: done_o=1 only in cycle T+2; dcache_flush_o and icache_flush_o stay 0 throughout; req_ready_o=1 in T+3.
- FENCE_I with wbuffer_empty_i held low for 5 cycles after acceptance: icache_flush_o pulses exactly once at T+7 and done_o at T+8.
- FLUSH_ALL with dcache_flush_ack_i delayed 10 cycles: dcache_flush_o is high for exactly 11 cycles, the icache_flush_o pulse follows on the next cycle, then done_o. A spurious ack while in DRAIN is ignored.
- TimeoutCycles=8, FLUSH_ALL with the write buffer non-empty for 20 cycles:
  - timeout_o rises after the 8th counted cycle and stays high through done_o.
  - The next accepted request clears it.
- rst_ni asserted mid-DFLUSH: all outputs return to reset values immediately. A new FENCE issued after reset release completes in 3 cycles.
- req_valid_i held continuously while alternating req_op_i between 1 and 2: each op is accepted only in IDLE, and the latched op decides the sequence regardless of later req_op_i changes.
